// File: rtl/async_fifo_lvl_if.sv
// Handshake and status bundle for async_fifo_lvl: write-side producer signals,
// read-side consumer signals, and the per-domain fill/error status.
`timescale 1ns/1ps

interface async_fifo_lvl_if #(
  parameter int DATAWIDTH = 16,
  parameter int ASIZE     = 10
);
  logic                 wen;
  logic [DATAWIDTH-1:0] wdata;
  logic                 wfull;
  logic                 walmost_full;
  logic [ASIZE:0]       wlevel;
  logic                 woverflow;

  logic                 ren;
  logic [DATAWIDTH-1:0] rdata;
  logic                 rvalid;
  logic                 rempty;
  logic                 ralmost_empty;
  logic [ASIZE:0]       rlevel;
  logic                 runderflow;

  modport master (
    output wen, wdata, ren,
    input  wfull, walmost_full, wlevel, woverflow,
    input  rdata, rvalid, rempty, ralmost_empty, rlevel, runderflow
  );

  modport slave (
    input  wen, wdata, ren,
    output wfull, walmost_full, wlevel, woverflow,
    output rdata, rvalid, rempty, ralmost_empty, rlevel, runderflow
  );
endinterface

// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with Gray-coded pointer crossing, per-domain fill levels,
// almost-full/almost-empty thresholds, read-valid strobe and sticky error flags.
`timescale 1ns/1ps

module async_fifo_lvl #(
  parameter int DATAWIDTH   = 16,
  parameter int ASIZE       = 10,
  parameter int AF_LEVEL    = (1 << ASIZE) - 4,
  parameter int AE_LEVEL    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wclk,
  input  logic              rclk,
  input  logic              rst_n,
  async_fifo_lvl_if.slave   bus
);

  localparam int DEPTH = 1 << ASIZE;

  typedef logic [ASIZE:0] ptr_t;

  localparam ptr_t AF_L = ptr_t'(AF_LEVEL);
  localparam ptr_t AE_L = ptr_t'(AE_LEVEL);

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATAWIDTH-1:0] mem [DEPTH];

  // ---------------- reset synchronisers: async assert, sync release
  logic [SYNC_STAGES-1:0] wrst_sync;
  logic [SYNC_STAGES-1:0] rrst_sync;
  logic                   wrst_n;
  logic                   rrst_n;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) wrst_sync <= '0;
    else        wrst_sync <= {wrst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) rrst_sync <= '0;
    else        rrst_sync <= {rrst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign wrst_n = wrst_sync[SYNC_STAGES-1];
  assign rrst_n = rrst_sync[SYNC_STAGES-1];

  // ---------------- write domain
  ptr_t wbin;
  ptr_t wgray;
  ptr_t wbin_next;
  ptr_t wgray_next;
  ptr_t rq_sync [SYNC_STAGES];
  ptr_t rq_gray;
  ptr_t rq_bin;
  ptr_t wlevel_next;
  logic winc;
  logic wfull_next;

  always_comb begin
    winc        = bus.wen & ~bus.wfull & wrst_n;
    wbin_next   = wbin + {{ASIZE{1'b0}}, winc};
    wgray_next  = bin2gray(wbin_next);
    rq_gray     = rq_sync[SYNC_STAGES-1];
    rq_bin      = gray2bin(rq_gray);
    // Full when the write pointer has lapped the read pointer exactly once.
    wfull_next  = (wgray_next == {~rq_gray[ASIZE:ASIZE-1], rq_gray[ASIZE-2:0]});
    wlevel_next = wbin_next - rq_bin;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) rq_sync[i] <= '0;
    end else begin
      rq_sync[0] <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++) rq_sync[i] <= rq_sync[i-1];
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin             <= '0;
      wgray            <= '0;
      bus.wfull        <= 1'b0;
      bus.walmost_full <= 1'b0;
      bus.wlevel       <= '0;
      bus.woverflow    <= 1'b0;
    end else begin
      wbin             <= wbin_next;
      wgray            <= wgray_next;
      bus.wfull        <= wfull_next;
      bus.walmost_full <= (wlevel_next >= AF_L);
      bus.wlevel       <= wlevel_next;
      bus.woverflow    <= bus.woverflow | (bus.wen & bus.wfull);
    end
  end

  always_ff @(posedge wclk) begin
    if (winc) mem[wbin[ASIZE-1:0]] <= bus.wdata;
  end

  // ---------------- read domain
  ptr_t rbin;
  ptr_t rgray;
  ptr_t rbin_next;
  ptr_t rgray_next;
  ptr_t wq_sync [SYNC_STAGES];
  ptr_t wq_gray;
  ptr_t wq_bin;
  ptr_t rlevel_next;
  logic rinc;
  logic rempty_next;

  always_comb begin
    rinc        = bus.ren & ~bus.rempty & rrst_n;
    rbin_next   = rbin + {{ASIZE{1'b0}}, rinc};
    rgray_next  = bin2gray(rbin_next);
    wq_gray     = wq_sync[SYNC_STAGES-1];
    wq_bin      = gray2bin(wq_gray);
    rempty_next = (rgray_next == wq_gray);
    rlevel_next = wq_bin - rbin_next;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) wq_sync[i] <= '0;
    end else begin
      wq_sync[0] <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++) wq_sync[i] <= wq_sync[i-1];
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin              <= '0;
      rgray             <= '0;
      bus.rempty        <= 1'b1;
      bus.ralmost_empty <= 1'b1;
      bus.rlevel        <= '0;
      bus.runderflow    <= 1'b0;
      bus.rvalid        <= 1'b0;
      bus.rdata         <= '0;
    end else begin
      rbin              <= rbin_next;
      rgray             <= rgray_next;
      bus.rempty        <= rempty_next;
      bus.ralmost_empty <= (rlevel_next <= AE_L);
      bus.rlevel        <= rlevel_next;
      bus.runderflow    <= bus.runderflow | (bus.ren & bus.rempty);
      bus.rvalid        <= rinc;
      if (rinc) bus.rdata <= mem[rbin[ASIZE-1:0]];
    end
  end

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Directed bench for async_fifo_lvl: depth 16, AF=12, AE=2, 50 MHz write / 133 MHz read.
`timescale 1ns/1ps

module tb_async_fifo_lvl;
  localparam int DW = 16;
  localparam int AS = 4;

  logic wclk = 1'b0;
  logic rclk = 1'b0;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;
  int wcount;
  int rcount;

  async_fifo_lvl_if #(.DATAWIDTH(DW), .ASIZE(AS)) bus();

  async_fifo_lvl #(
    .DATAWIDTH(DW), .ASIZE(AS), .AF_LEVEL(12), .AE_LEVEL(2), .SYNC_STAGES(2)
  ) dut (
    .wclk (wclk),
    .rclk (rclk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #10   wclk = ~wclk;
  always #3.75 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_one(input logic [DW-1:0] d);
    @(negedge wclk);
    bus.wen   = 1'b1;
    bus.wdata = d;
    @(posedge wclk);
    #1;
    bus.wen = 1'b0;
  endtask

  task automatic read_one();
    @(negedge rclk);
    bus.ren = 1'b1;
    @(posedge rclk);
    #1;
    bus.ren = 1'b0;
  endtask

  task automatic wait_not_empty(input string tag, input int max_edges);
    logic [31:0] found;
    found = 0;
    for (int i = 0; i < max_edges; i++) begin
      @(posedge rclk);
      #1;
      if (!bus.rempty) begin
        found = 1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  task automatic pulse_reset(input int low_ns);
    @(negedge wclk);
    rst_n = 1'b0;
    #(low_ns);
    rst_n = 1'b1;
    repeat (6) @(posedge wclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.wen   = 1'b0;
    bus.wdata = '0;
    bus.ren   = 1'b0;

    // Reset state
    #100;
    check("rst_rempty", bus.rempty, 1);
    check("rst_ralmost_empty", bus.ralmost_empty, 1);
    check("rst_wfull", bus.wfull, 0);
    check("rst_walmost_full", bus.walmost_full, 0);
    check("rst_wlevel", bus.wlevel, 0);
    check("rst_rlevel", bus.rlevel, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_woverflow", bus.woverflow, 0);
    check("rst_runderflow", bus.runderflow, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge wclk);

    // Fill to full, then one refused write
    for (int i = 0; i < 16; i++) begin
      write_one(16'(i));
      if (i == 10) check("fill_af_low", bus.walmost_full, 0);
      if (i == 11) begin
        check("fill_af_high", bus.walmost_full, 1);
        check("fill_wlevel12", bus.wlevel, 12);
      end
      if (i == 14) check("fill_notfull", bus.wfull, 0);
      if (i == 15) begin
        check("fill_full", bus.wfull, 1);
        check("fill_wlevel16", bus.wlevel, 16);
      end
    end
    write_one(16'hDEAD);
    check("ovf_flag", bus.woverflow, 1);
    check("ovf_wlevel", bus.wlevel, 16);
    check("ovf_full", bus.wfull, 1);

    repeat (6) @(posedge rclk);
    #1;
    check("full_rlevel", bus.rlevel, 16);
    check("full_rempty", bus.rempty, 0);
    check("full_ralmost", bus.ralmost_empty, 0);

    // Drain
    for (int i = 0; i < 16; i++) begin
      read_one();
      check("drain_rvalid", bus.rvalid, 1);
      check("drain_rdata", bus.rdata, 32'(i));
      if (i == 12) check("drain_ae_low", bus.ralmost_empty, 0);
      if (i == 13) begin
        check("drain_ae_high", bus.ralmost_empty, 1);
        check("drain_rlevel2", bus.rlevel, 2);
      end
      if (i == 14) check("drain_notempty", bus.rempty, 0);
      if (i == 15) begin
        check("drain_empty", bus.rempty, 1);
        check("drain_rlevel0", bus.rlevel, 0);
      end
    end
    read_one();
    check("udf_flag", bus.runderflow, 1);
    check("udf_rvalid", bus.rvalid, 0);
    check("udf_rdata_hold", bus.rdata, 16'h000F);

    repeat (4) @(posedge wclk);
    #1;
    check("drained_wfull", bus.wfull, 0);
    check("drained_wlevel", bus.wlevel, 0);
    check("drained_walmost", bus.walmost_full, 0);

    // Latency of a single word
    write_one(16'hA5A5);
    wait_not_empty("lat_rempty_fall", 3);
    read_one();
    check("lat_rvalid", bus.rvalid, 1);
    check("lat_rdata", bus.rdata, 16'hA5A5);
    @(posedge rclk);
    #1;
    check("lat_rvalid_pulse", bus.rvalid, 0);
    check("lat_rdata_hold", bus.rdata, 16'hA5A5);

    // Reset clears sticky flags before streaming
    pulse_reset(40);
    check("rst2_woverflow", bus.woverflow, 0);
    check("rst2_runderflow", bus.runderflow, 0);
    check("rst2_rempty", bus.rempty, 1);
    check("rst2_wlevel", bus.wlevel, 0);

    // Random stream of 1000 incrementing words
    wcount = 0;
    rcount = 0;
    fork
      begin
        while (wcount < 1000) begin
          @(negedge wclk);
          if (!bus.wfull && $urandom_range(0, 3) == 0) begin
            bus.wen   = 1'b1;
            bus.wdata = 16'(16'h1000 + wcount);
            wcount++;
          end else begin
            bus.wen = 1'b0;
          end
        end
        @(negedge wclk);
        bus.wen = 1'b0;
      end
      begin
        for (int c = 0; c < 40000 && rcount < 1000; c++) begin
          @(negedge rclk);
          bus.ren = !bus.rempty && ($urandom_range(0, 1) == 1);
          @(posedge rclk);
          #1;
          if (bus.rvalid) begin
            check("stream_data", bus.rdata, 32'(16'(16'h1000 + rcount)));
            rcount++;
          end
        end
        bus.ren = 1'b0;
      end
    join
    repeat (6) @(posedge wclk);
    #1;
    check("stream_count", rcount, 1000);
    check("stream_woverflow", bus.woverflow, 0);
    check("stream_runderflow", bus.runderflow, 0);
    check("stream_rempty", bus.rempty, 1);
    check("stream_wlevel", bus.wlevel, 0);

    // Reset mid-operation with 9 words stored
    read_one();
    check("mid_udf_set", bus.runderflow, 1);
    for (int i = 0; i < 9; i++) write_one(16'(16'h0050 + i));
    repeat (6) @(posedge rclk);
    #1;
    check("mid_wlevel9", bus.wlevel, 9);
    check("mid_rlevel9", bus.rlevel, 9);
    pulse_reset(50);
    check("mid_wlevel0", bus.wlevel, 0);
    check("mid_rlevel0", bus.rlevel, 0);
    check("mid_rempty", bus.rempty, 1);
    check("mid_ralmost", bus.ralmost_empty, 1);
    check("mid_runderflow", bus.runderflow, 0);
    check("mid_woverflow", bus.woverflow, 0);
    write_one(16'h1234);
    wait_not_empty("mid_rempty_fall", 10);
    read_one();
    check("mid_first_rvalid", bus.rvalid, 1);
    check("mid_first_rdata", bus.rdata, 16'h1234);
    check("mid_empty_after", bus.rempty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/async_fifo_lvl.md
# async_fifo_lvl

Dual-clock FIFO that carries DATAWIDTH-bit words from the wclk domain to the rclk domain with Gray-coded pointers and a parametrised synchroniser depth. It extends the basic full/empty FIFO with per-domain fill levels, programmable almost-full and almost-empty thresholds, a read-valid strobe, and sticky overflow/underflow error flags. It sits between 50 MHz write-side producers and 133 MHz read-side consumers in the QSPI datapath.

## Interface
- DATAWIDTH, 16: word width in bits.
- ASIZE, 10: address bits. Depth = 2^ASIZE words. Legal range 2..12.
- AF_LEVEL, 2^ASIZE-4: walmost_full asserts when wlevel >= AF_LEVEL. Legal range 1..2^ASIZE.
- AE_LEVEL, 4: ralmost_empty asserts when rlevel <= AE_LEVEL. Legal range 0..2^ASIZE-1.
- SYNC_STAGES, 2: flops in each pointer and reset synchroniser. Legal range 2..4.

Ports:
- wclk  in  1  write-domain clock.
- rclk  in  1  read-domain clock.
- rst_n  in  1  reset, asynchronous, active-low. Serves both domains.
- wen  in  1  write request.
- wdata  in  DATAWIDTH  write word.
- wfull  out  1  FIFO full (wclk domain).
- walmost_full  out  1  wlevel >= AF_LEVEL.
- wlevel  out  ASIZE+1  words stored, as seen from the write side.
- woverflow  out  1  sticky: a write was attempted while wfull.
- ren  in  1  read request.
- rdata  out  DATAWIDTH  read word, registered.
- rvalid  out  1  rdata holds a newly read word.
- rempty  out  1  FIFO empty (rclk domain).
- ralmost_empty  out  1  rlevel <= AE_LEVEL.
- rlevel  out  ASIZE+1  words stored, as seen from the read side.
- runderflow  out  1  sticky: a read was attempted while rempty.

## Operation
- Reset:
  - rst_n asserts asynchronously in both domains.
  - Deassertion is synchronised separately in each domain through SYNC_STAGES flops.
  - While reset is active or pending release in a domain, that domain's outputs hold their reset values: wfull=0, walmost_full=(AF_LEVEL==0 ? 1 : 0) → effectively 0, wlevel=0, woverflow=0, rempty=1, ralmost_empty=1, rlevel=0, rdata=0, rvalid=0, runderflow=0.
- Pointers:
  - Binary and Gray pointers are ASIZE+1 bits wide; the extra MSB is the wrap bit.
  - Each Gray pointer crosses to the other domain through SYNC_STAGES flops.
- Write (wen=1 and wfull=0 at a wclk edge):
  - mem[wptr[ASIZE-1:0]] <= wdata.
  - wptr increments.
- Write refused (wen=1 and wfull=1): no memory or pointer change; woverflow <= 1.
- Read (ren=1 and rempty=0 at an rclk edge):
  - rdata <= mem[rptr[ASIZE-1:0]].
  - rptr increments.
  - rvalid <= 1.
- Other rclk edges:
  - rvalid <= 0 and rdata holds.
  - If ren=1 and rempty=1: runderflow <= 1.
- Flags are registered and computed from next-state pointers:
  - wfull = (wgray_next == {~rq_gray[ASIZE:ASIZE-1], rq_gray[ASIZE-2:0]}), where rq_gray is the synchronised read pointer.
  - rempty = (rgray_next == wq_gray), where wq_gray is the synchronised write pointer.
- Levels, modulo 2^(ASIZE+1), from next-state values:
  - wlevel = wbin_next - bin(rq_gray). Range 0..2^ASIZE.
  - rlevel = bin(wq_gray) - rbin_next.
- Levels are conservative: wlevel never under-reports and rlevel never over-reports, because each side sees the other's pointer late.
- Sticky flags clear only on reset.
- Wrap-around: pointers roll from 2^(ASIZE+1)-1 to 0 with no special handling.

## Timing
- Flag and level updates:
  - wfull, walmost_full and wlevel update on the same wclk edge as the causing write.
  - rempty, ralmost_empty and rlevel update on the same rclk edge as the causing read.
- Write to rempty deassertion: a write at wclk edge W makes rempty fall within SYNC_STAGES+1 rclk edges after W.
- Read to wfull deassertion: a read at rclk edge R makes wfull fall within SYNC_STAGES+1 wclk edges after R.
- Read latency: a read accepted at rclk edge R presents rdata with rvalid=1 after R, held for one rclk cycle.
- Simultaneous read and write at the same level: each domain's flags remain correct and conservative, with no lost or duplicated word.
- Reset mid-operation:
  - Contents are discarded and both pointers return to 0.
  - The FIFO is empty after each domain's reset synchroniser releases.

## Test plan
Bench setup: ASIZE=4 (depth 16), AF_LEVEL=12, AE_LEVEL=2, SYNC_STAGES=2, wclk 50 MHz, rclk 133 MHz.
- Reset check: hold rst_n=0 for 100 ns, no traffic → rempty=1, ralmost_empty=1, wfull=0, wlevel=0, rlevel=0, rdata=0, rvalid=0, woverflow=0, runderflow=0.
- Fill with ren=0: write 0x0000..0x000F on consecutive cycles → walmost_full rises on the 12th write's edge (wlevel=12); wfull and wlevel=16 on the 16th write's edge. A 17th wen → woverflow=1 and the data is not stored.
- Drain: from full, ren=1 continuously → rdata sequence 0x0000..0x000F, each with one rvalid pulse. rempty rises on the edge of the 16th read; ralmost_empty rises at rlevel=2. A further ren → runderflow=1.
- Latency: single write 0xA5A5 into an empty FIFO → rempty falls within 3 rclk edges. ren on the next edge → rdata=0xA5A5 with rvalid=1 one cycle after.
- Wrap and stream: random wen (about 25% duty) and random ren, 1000 words, incrementing data → read order matches write order exactly, no overflow, no underflow, and pointers wrap at least 30 times.
- Reset mid-operation: with 9 words stored, pulse rst_n low for 50 ns → wlevel=0, rlevel=0, rempty=1, sticky flags cleared. The next written word 0x1234 is the first word read.
